// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus-access block: bus widths and FSM state encoding.
// Also used by the timing stage and the bus arbiter.
package cpu_bus_pkg;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_FETCH_WAIT = 2'd1,
        S_MEM_WAIT   = 2'd2
    } state_t;

endpackage

// File: rtl/cpu_bus_access.sv
// Bus-side partner of the CPU timing stage: runs instruction fetches and load/store
// transactions, and holds the timing stage via busy until each access completes.
module cpu_bus_access #(
    parameter int ADDR_W = cpu_bus_pkg::ADDR_W,
    parameter int DATA_W = cpu_bus_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch,
    input  logic              readMem,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              busy,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              bus_start,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_we,
    input  logic [DATA_W-1:0] bus_q,
    input  logic              bus_done
);
    import cpu_bus_pkg::*;

    state_t            state_q, state_d;
    logic              done_q, done_d;
    logic              bus_start_q, bus_start_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              need_mem;

    assign need_mem = mem_read | mem_write;

    // done is registered, so busy is high in the first cycle of every strobe.
    assign busy = ~done_q & (fetch | (readMem & need_mem));

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        bus_start_d = 1'b0;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_data_d  = bus_data_q;
        instr_d     = instr_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (fetch && !done_q) begin
                    bus_start_d = 1'b1;
                    bus_addr_d  = pc;
                    bus_we_d    = 1'b0;
                    state_d     = S_FETCH_WAIT;
                end else if (readMem && need_mem && !done_q) begin
                    bus_start_d = 1'b1;
                    bus_addr_d  = mem_addr;
                    bus_we_d    = mem_write;
                    bus_data_d  = mem_wdata;
                    state_d     = S_MEM_WAIT;
                end
            end
            S_FETCH_WAIT: begin
                if (bus_done) begin
                    // A fetch strobe that has already dropped must not leave done set.
                    instr_d = bus_q;
                    done_d  = fetch;
                    state_d = S_IDLE;
                end
            end
            S_MEM_WAIT: begin
                if (bus_done) begin
                    if (!bus_we_q) begin
                        mem_rdata_d = bus_q;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!fetch && !readMem) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            bus_start_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
            instr_q     <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            bus_start_q <= bus_start_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_data_q  <= bus_data_d;
            instr_q     <= instr_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus_start = bus_start_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_data  = bus_data_q;
    assign instr     = instr_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_cpu_bus_access.sv
// Directed bench for cpu_bus_access: a per-cycle vector table followed by a
// fetch/getRegs/readMem/writeBack loop against a small bus responder.
module tb_cpu_bus_access;

    localparam int AW = 27;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset, fetch, readMem, mem_read, mem_write;
    logic [AW-1:0] pc, mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy, bus_start, bus_we;
    logic [DW-1:0] instr, mem_rdata, bus_data, bus_q;
    logic [AW-1:0] bus_addr;
    logic          bus_done;

    logic          tb_done;
    logic [DW-1:0] tb_q;
    logic          auto_bus = 1'b0;
    logic          resp_done = 1'b0;
    logic [DW-1:0] resp_q = '0;
    logic [AW-1:0] resp_addr = '0;
    int            resp_cnt = 0;

    int n_pass = 0;
    int n_total = 0;

    assign bus_done = auto_bus ? resp_done : tb_done;
    assign bus_q    = auto_bus ? resp_q    : tb_q;

    always #5 clk = ~clk;

    cpu_bus_access dut (
        .clk       (clk),
        .reset     (reset),
        .fetch     (fetch),
        .readMem   (readMem),
        .pc        (pc),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .busy      (busy),
        .instr     (instr),
        .mem_rdata (mem_rdata),
        .bus_start (bus_start),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .bus_we    (bus_we),
        .bus_q     (bus_q),
        .bus_done  (bus_done)
    );

    function automatic logic [DW-1:0] bus_mem(input logic [AW-1:0] a);
        return {5'b0, a} ^ 32'hA5A5_0000;
    endfunction

    // Responder: bus_done three cycles after the cycle in which bus_start is seen.
    always @(posedge clk) begin
        resp_done <= 1'b0;
        if (resp_cnt != 0) begin
            resp_cnt <= resp_cnt - 1;
            if (resp_cnt == 1) begin
                resp_done <= 1'b1;
                resp_q    <= bus_mem(resp_addr);
            end
        end else if (bus_start) begin
            resp_cnt  <= 2;
            resp_addr <= bus_addr;
        end
    end

    typedef struct {
        logic          rst, fe, rm, rd, wr, dn;
        logic [AW-1:0] pc, ma;
        logic [DW-1:0] wd, q;
        logic          e_busy, e_st, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data, e_instr, e_rdata;
    } vec_t;

    function automatic vec_t v(
        input logic rst, fe, rm, rd, wr, dn,
        input logic [AW-1:0] p, ma, input logic [DW-1:0] wd, q,
        input logic e_busy, e_st, e_we, input logic [AW-1:0] e_addr,
        input logic [DW-1:0] e_data, e_instr, e_rdata);
        vec_t r;
        r = '{rst, fe, rm, rd, wr, dn, p, ma, wd, q,
              e_busy, e_st, e_we, e_addr, e_data, e_instr, e_rdata};
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    endtask

    task automatic drive(input vec_t x);
        reset = x.rst; fetch = x.fe; readMem = x.rm; mem_read = x.rd; mem_write = x.wr;
        tb_done = x.dn; pc = x.pc; mem_addr = x.ma; mem_wdata = x.wd; tb_q = x.q;
    endtask

    // Holds one strobe until busy drops; returns the number of busy cycles.
    task automatic access(input string nm, output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 30) begin
            n++;
            @(negedge clk);
        end
        $display("access %s: %0d busy cycles, bus_addr=%h instr=%h mem_rdata=%h",
                 nm, n, bus_addr, instr, mem_rdata);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        fetch = 1'b0; readMem = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    localparam logic [DW-1:0] DB = 32'hDEADBEEF;
    localparam logic [DW-1:0] CF = 32'hCAFEF00D;
    localparam logic [DW-1:0] SD = 32'h12345678;
    localparam logic [DW-1:0] RQ = 32'h11112222;

    vec_t vecs[$];

    initial begin
        int n;
        logic [AW-1:0] p0, a0;

        //           rst fe rm rd wr dn  pc      ma      wd  q             busy st we addr    data instr rdata
        vecs.push_back(v(1,0,0,0,0,0, 0,      0,      0,  0,            0,0,0, 0,      0,  0,  0));
        // fetch, bus_done one cycle after bus_start
        vecs.push_back(v(0,1,0,0,0,0, 'h10,   0,      0,  0,            1,0,0, 0,      0,  0,  0));
        vecs.push_back(v(0,1,0,0,0,0, 'h10,   0,      0,  0,            1,1,0, 'h10,   0,  0,  0));
        vecs.push_back(v(0,1,0,0,0,1, 'h10,   0,      0,  DB,           1,0,0, 'h10,   0,  0,  0));
        vecs.push_back(v(0,1,0,0,0,0, 'h10,   0,      0,  0,            0,0,0, 'h10,   0,  DB, 0));
        vecs.push_back(v(0,0,0,0,0,0, 0,      0,      0,  0,            0,0,0, 'h10,   0,  DB, 0));
        // load, bus_done five cycles after bus_start
        vecs.push_back(v(0,0,1,1,0,0, 0,      'h100,  0,  0,            1,0,0, 'h10,   0,  DB, 0));
        vecs.push_back(v(0,0,1,1,0,0, 0,      'h100,  0,  0,            1,1,0, 'h100,  0,  DB, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(0,0,1,1,0,0, 0,  'h100,  0,  0,            1,0,0, 'h100,  0,  DB, 0));
        vecs.push_back(v(0,0,1,1,0,1, 0,      'h100,  0,  CF,           1,0,0, 'h100,  0,  DB, 0));
        vecs.push_back(v(0,0,1,1,0,0, 0,      'h100,  0,  0,            0,0,0, 'h100,  0,  DB, CF));
        vecs.push_back(v(0,0,0,0,0,0, 0,      0,      0,  0,            0,0,0, 'h100,  0,  DB, CF));
        // store with both mem_read and mem_write set
        vecs.push_back(v(0,0,1,1,1,0, 0,      'h200,  SD, 0,            1,0,0, 'h100,  0,  DB, CF));
        vecs.push_back(v(0,0,1,1,1,0, 0,      'h200,  SD, 0,            1,1,1, 'h200,  SD, DB, CF));
        vecs.push_back(v(0,0,1,1,1,1, 0,      'h200,  SD, 32'hFFFFFFFF, 1,0,1, 'h200,  SD, DB, CF));
        vecs.push_back(v(0,0,1,1,1,0, 0,      'h200,  SD, 0,            0,0,1, 'h200,  SD, DB, CF));
        vecs.push_back(v(0,0,0,0,0,0, 0,      0,      0,  0,            0,0,1, 'h200,  SD, DB, CF));
        // readMem for a non-memory instruction
        vecs.push_back(v(0,0,1,0,0,0, 0,      'h300,  0,  0,            0,0,1, 'h200,  SD, DB, CF));
        vecs.push_back(v(0,0,1,0,0,0, 0,      'h300,  0,  0,            0,0,1, 'h200,  SD, DB, CF));
        vecs.push_back(v(0,0,0,0,0,0, 0,      0,      0,  0,            0,0,1, 'h200,  SD, DB, CF));
        // reset in S_MEM_WAIT, then a stale bus_done
        vecs.push_back(v(0,0,1,1,0,0, 0,      'h40,   0,  0,            1,0,1, 'h200,  SD, DB, CF));
        vecs.push_back(v(0,0,1,1,0,0, 0,      'h40,   0,  0,            1,1,0, 'h40,   0,  DB, CF));
        vecs.push_back(v(1,0,1,1,0,0, 0,      'h40,   0,  0,            1,0,0, 'h40,   0,  DB, CF));
        vecs.push_back(v(0,0,0,0,0,0, 0,      0,      0,  0,            0,0,0, 0,      0,  0,  0));
        vecs.push_back(v(0,0,0,0,0,1, 0,      0,      0,  32'h55AA55AA, 0,0,0, 0,      0,  0,  0));
        vecs.push_back(v(0,0,0,0,0,0, 0,      0,      0,  0,            0,0,0, 0,      0,  0,  0));
        // next load must start from S_IDLE
        vecs.push_back(v(0,0,1,1,0,0, 0,      'h44,   0,  0,            1,0,0, 0,      0,  0,  0));
        vecs.push_back(v(0,0,1,1,0,0, 0,      'h44,   0,  0,            1,1,0, 'h44,   0,  0,  0));
        vecs.push_back(v(0,0,1,1,0,1, 0,      'h44,   0,  RQ,           1,0,0, 'h44,   0,  0,  0));
        vecs.push_back(v(0,0,1,1,0,0, 0,      'h44,   0,  0,            0,0,0, 'h44,   0,  0,  RQ));
        vecs.push_back(v(0,0,0,0,0,0, 0,      0,      0,  0,            0,0,0, 'h44,   0,  0,  RQ));

        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            chk("busy",      i, 32'(busy),      32'(vecs[i].e_busy));
            chk("bus_start", i, 32'(bus_start), 32'(vecs[i].e_st));
            chk("bus_we",    i, 32'(bus_we),    32'(vecs[i].e_we));
            chk("bus_addr",  i, 32'(bus_addr),  32'(vecs[i].e_addr));
            chk("bus_data",  i, bus_data,       vecs[i].e_data);
            chk("instr",     i, instr,          vecs[i].e_instr);
            chk("mem_rdata", i, mem_rdata,      vecs[i].e_rdata);
            @(posedge clk);
            #1;
        end

        // Timing-stage loop: fetch, getRegs, readMem(load), writeBack, fetch.
        auto_bus = 1'b1;
        p0 = 27'h0000020;
        a0 = 27'h0000400;

        fetch = 1'b1; pc = p0;
        access("fetch0", n);
        chk("loop_fetch0_cycles", 0, 32'(n), 32'd5);
        chk("loop_fetch0_instr",  0, instr, bus_mem(p0));
        chk("loop_fetch0_addr",   0, 32'(bus_addr), 32'(p0));
        idle_cycle();

        @(posedge clk); #1;
        readMem = 1'b1; mem_read = 1'b1; mem_addr = a0;
        access("load", n);
        chk("loop_load_cycles", 1, 32'(n), 32'd5);
        chk("loop_load_rdata",  1, mem_rdata, bus_mem(a0));
        chk("loop_load_instr",  1, instr, bus_mem(p0));
        chk("loop_load_we",     1, 32'(bus_we), 32'd0);
        idle_cycle();

        @(posedge clk); #1;
        fetch = 1'b1; pc = p0 + 27'd1;
        access("fetch1", n);
        chk("loop_fetch1_cycles", 2, 32'(n), 32'd5);
        chk("loop_fetch1_addr",   2, 32'(bus_addr), 32'(p0 + 27'd1));
        chk("loop_fetch1_instr",  2, instr, bus_mem(p0 + 27'd1));
        chk("loop_fetch1_rdata",  2, mem_rdata, bus_mem(a0));
        idle_cycle();
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
